quant_shift: RTL and testbench

Dynamic fixed-point requantizer that sits directly downstream of the per-layer max-absolute-value stage. It takes the layer's `maxAbs` with its `convFinish_flag` pulse and derives a right-shift amount by scanning for the most significant set bit. It then converts a stream of 16-lane signed 32-bit convolution results into 16-lane signed 8-bit values, using that shift with round-half-up and saturation. Its output feeds the activation write-back buffer.

---
 rtl/quant_shift_if.sv | 34 +++
 rtl/quant_shift.sv | 132 +++++++++++++
 tb/tb_quant_shift.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/quant_shift_if.sv
`default_nettype none
// ============================================================================
// Module   : quant_shift_if
// Brief    : Bus bundle for the quant_shift requantizer (control, stream in,
//            quantized stream out).
// Revision : 1.0 - initial release
// ============================================================================
interface quant_shift_if #(
  parameter int LANES = 16,
  parameter int IN_W  = 32,
  parameter int OUT_W = 8
);
  logic                   maxAbs_valid;
  logic [IN_W-1:0]        maxAbs;
  logic                   data_valid;
  logic [LANES*IN_W-1:0]  data_in;
  logic                   busy;
  logic                   shift_valid;
  logic [4:0]             shift_out;
  logic                   q_valid;
  logic [LANES*OUT_W-1:0] q_data;
  logic                   drop_err;

  modport master (
    output maxAbs_valid, maxAbs, data_valid, data_in,
    input  busy, shift_valid, shift_out, q_valid, q_data, drop_err
  );

  modport slave (
    input  maxAbs_valid, maxAbs, data_valid, data_in,
    output busy, shift_valid, shift_out, q_valid, q_data, drop_err
  );
endinterface
`default_nettype wire

// File: rtl/quant_shift.sv
`default_nettype none
// ============================================================================
// Module   : quant_shift
// Brief    : Derives a right shift from the layer max-abs via an MSB scan, then
//            requantizes 16 x s32 lanes to s8 with round-half-up + saturation.
// Revision : 1.0 - initial release
// ============================================================================
module quant_shift #(
  parameter int LANES = 16,
  parameter int IN_W  = 32,
  parameter int OUT_W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  quant_shift_if.slave bus
);

  localparam int IDX_W = $clog2(IN_W);
  localparam int SUM_W = IN_W + 1;
  localparam logic [IDX_W-1:0]        IDX_TOP = IDX_W'(IN_W - 1);
  localparam logic [IDX_W-1:0]        SAT_P   = IDX_W'(OUT_W - 2);
  localparam logic signed [SUM_W-1:0] ONE     = SUM_W'(1);
  localparam logic signed [SUM_W-1:0] SAT_HI  = SUM_W'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [SUM_W-1:0] SAT_LO  = SUM_W'(-(1 << (OUT_W - 1)));

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    ARMED = 2'd2
  } state_t;

  state_t                   state;
  logic [IN_W-1:0]          scan_reg;
  logic [IDX_W-1:0]         idx;
  logic                     busy_reg;
  logic                     shift_valid_reg;
  logic [4:0]               shift_reg;
  logic                     drop_reg;

  logic                     accept;
  logic signed [SUM_W-1:0]  rnd;
  logic [LANES*SUM_W-1:0]   r_bus;
  logic [LANES*OUT_W-1:0]   sat_bus;

  logic                     s1_valid;
  logic [LANES*SUM_W-1:0]   s1_data;
  logic                     q_valid_reg;
  logic [LANES*OUT_W-1:0]   q_data_reg;

  // A new max-abs restarts the scan from any state, including mid-scan.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= IDLE;
      scan_reg        <= '0;
      idx             <= '0;
      busy_reg        <= 1'b0;
      shift_valid_reg <= 1'b0;
      shift_reg       <= '0;
    end else if (bus.maxAbs_valid) begin
      state           <= SCAN;
      scan_reg        <= bus.maxAbs;
      idx             <= IDX_TOP;
      busy_reg        <= 1'b1;
      shift_valid_reg <= 1'b0;
    end else if (state == SCAN) begin
      if (scan_reg[idx] || (idx == '0)) begin
        state           <= ARMED;
        busy_reg        <= 1'b0;
        shift_valid_reg <= 1'b1;
        shift_reg       <= (idx > SAT_P) ? 5'(idx - SAT_P) : 5'd0;
      end else begin
        idx <= idx - IDX_W'(1);
      end
    end
  end

  // Acceptance looks at the current state only, so a beat coinciding with a
  // new max-abs in ARMED still goes through with the old shift.
  assign accept = bus.data_valid && (state == ARMED);
  assign rnd    = (shift_reg == 5'd0) ? '0 : (ONE << (shift_reg - 5'd1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      drop_reg <= 1'b0;
    end else if (bus.data_valid && (state != ARMED)) begin
      drop_reg <= 1'b1;
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic signed [SUM_W-1:0] ext;
    logic signed [SUM_W-1:0] sum;
    logic signed [SUM_W-1:0] held;

    assign ext  = {bus.data_in[k*IN_W + IN_W - 1], bus.data_in[k*IN_W +: IN_W]};
    assign sum  = ext + rnd;
    assign r_bus[k*SUM_W +: SUM_W] = sum >>> shift_reg;

    assign held = s1_data[k*SUM_W +: SUM_W];
    assign sat_bus[k*OUT_W +: OUT_W] = (held > SAT_HI) ? SAT_HI[OUT_W-1:0] :
                                       (held < SAT_LO) ? SAT_LO[OUT_W-1:0] :
                                                         held[OUT_W-1:0];
  end

  // The shift is applied on entry, so in-flight beats keep their own shift.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid    <= 1'b0;
      s1_data     <= '0;
      q_valid_reg <= 1'b0;
      q_data_reg  <= '0;
    end else begin
      s1_valid    <= accept;
      q_valid_reg <= s1_valid;
      if (accept) begin
        s1_data <= r_bus;
      end
      if (s1_valid) begin
        q_data_reg <= sat_bus;
      end
    end
  end

  assign bus.busy        = busy_reg;
  assign bus.shift_valid = shift_valid_reg;
  assign bus.shift_out   = shift_reg;
  assign bus.q_valid     = q_valid_reg;
  assign bus.q_data      = q_data_reg;
  assign bus.drop_err    = drop_reg;

endmodule
`default_nettype wire

// File: tb/tb_quant_shift.sv
`default_nettype none
// ============================================================================
// Module   : tb_quant_shift
// Brief    : Scoreboard bench for quant_shift with a arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_quant_shift;

  localparam int LANES = 16;
  localparam int IN_W  = 32;
  localparam int OUT_W = 8;
  localparam int DW    = LANES * IN_W;
  localparam int QW    = LANES * OUT_W;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  quant_shift_if #(.LANES(LANES), .IN_W(IN_W), .OUT_W(OUT_W)) bus ();

  quant_shift #(.LANES(LANES), .IN_W(IN_W), .OUT_W(OUT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [QW-1:0] exp;
    int            due;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  bit   mon_en   = 1'b0;

  // Behavioural model of the control side.
  int m_scan_left = 0;
  bit m_armed     = 1'b0;
  bit m_drop      = 1'b0;
  int m_shift     = 0;
  int m_pend      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, logic [QW-1:0] act, logic [QW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic int ref_msb(logic [IN_W-1:0] m);
    int p = 0;
    for (int i = 0; i < IN_W; i++) if (m[i]) p = i;
    return p;
  endfunction

  function automatic int ref_shift(logic [IN_W-1:0] m);
    int p = ref_msb(m);
    return (p > OUT_W - 2) ? p - (OUT_W - 2) : 0;
  endfunction

  // floor((x + 2^(s-1)) / 2^s), then clamp to the signed output range.
  function automatic logic [OUT_W-1:0] ref_q(logic [IN_W-1:0] xb, int s);
    longint x, d, v, q;
    x = longint'($signed(xb));
    d = longint'(1) << s;
    v = x + ((s > 0) ? d / 2 : 0);
    q = v / d;
    if ((v % d) != 0 && v < 0) q = q - 1;
    if (q > 127)  q = 127;
    if (q < -128) q = -128;
    return OUT_W'(q);
  endfunction

  function automatic logic [QW-1:0] ref_beat(logic [DW-1:0] din, int s);
    logic [QW-1:0] r;
    for (int k = 0; k < LANES; k++) r[k*OUT_W +: OUT_W] = ref_q(din[k*IN_W +: IN_W], s);
    return r;
  endfunction

  function automatic logic [DW-1:0] rand_beat();
    logic [DW-1:0] r;
    for (int k = 0; k < LANES; k++) begin
      logic [IN_W-1:0] v;
      v = $urandom;
      v = IN_W'($signed(v) >>> $urandom_range(0, 31));
      r[k*IN_W +: IN_W] = v;
    end
    return r;
  endfunction

  // One clock: the model consumes what the DUT just sampled, then pulses clear.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      m_armed = 1'b0; m_scan_left = 0; m_drop = 1'b0; m_shift = 0;
      sbq.delete();
    end else begin
      if (bus.data_valid) begin
        if (m_armed) begin
          e.exp = ref_beat(bus.data_in, m_shift);
          e.due = cyc + 1;
          sbq.push_back(e);
        end else begin
          m_drop = 1'b1;
        end
      end
      if (bus.maxAbs_valid) begin
        m_armed     = 1'b0;
        m_scan_left = IN_W - ref_msb(bus.maxAbs);
        m_pend      = ref_shift(bus.maxAbs);
      end else if (m_scan_left > 0) begin
        m_scan_left--;
        if (m_scan_left == 0) begin
          m_armed = 1'b1;
          m_shift = m_pend;
        end
      end
    end
    bus.maxAbs_valid = 1'b0;
    bus.data_valid   = 1'b0;
  endtask

  task automatic send(logic [DW-1:0] din);
    bus.data_valid = 1'b1;
    bus.data_in    = din;
    tick();
  endtask

  task automatic arm(logic [IN_W-1:0] m, string nm);
    int n = 0;
    bus.maxAbs       = m;
    bus.maxAbs_valid = 1'b1;
    tick();
    while (bus.busy && n < 100) begin
      n++;
      tick();
    end
    chk({nm, "_busy_cycles"}, n, IN_W - ref_msb(m));
    chk({nm, "_shift_valid"}, bus.shift_valid, 1'b1);
    chk({nm, "_shift_out"}, bus.shift_out, ref_shift(m));
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      chk("busy", bus.busy, m_scan_left > 0);
      chk("shift_valid", bus.shift_valid, m_armed);
      chk("shift_out", bus.shift_out, m_shift);
      chk("drop_err", bus.drop_err, m_drop);
      if (bus.q_valid) begin
        if (sbq.size() == 0) begin
          chk("q_valid_spurious", bus.q_valid, 1'b0);
        end else begin
          mon_e = sbq.pop_front();
          chk("q_latency", cyc, mon_e.due);
          chk("q_data", bus.q_data, mon_e.exp);
        end
      end else if (sbq.size() > 0 && sbq[0].due <= cyc) begin
        chk("q_valid_missing", bus.q_valid, 1'b1);
        void'(sbq.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] din;
    int n;
    bus.maxAbs_valid = 1'b0;
    bus.maxAbs       = '0;
    bus.data_valid   = 1'b0;
    bus.data_in      = '0;

    rst_n = 1'b0;
    repeat (3) tick();
    mon_en = 1'b1;
    chk("rst_q_data", bus.q_data, '0);
    chk("rst_q_valid", bus.q_valid, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    rst_n = 1'b1;
    tick();

    // Beat in IDLE is dropped, and only reset clears the flag.
    send(rand_beat());
    tick();
    chk("drop_err_idle", bus.drop_err, 1'b1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("drop_err_cleared", bus.drop_err, 1'b0);
    tick();

    arm(32'd1000, "max1000");
    din = rand_beat();
    din[0*IN_W +: IN_W] = 32'd1000;
    din[1*IN_W +: IN_W] = -32'sd1000;
    din[2*IN_W +: IN_W] = 32'd1020;
    din[3*IN_W +: IN_W] = -32'sd1028;
    din[4*IN_W +: IN_W] = 32'd3;
    send(din);
    tick();
    chk("s3_q_valid", bus.q_valid, 1'b1);
    chk("s3_lanes", bus.q_data[5*OUT_W-1:0], 40'h00_80_7F_83_7D);
    tick();

    arm(32'd100, "max100");
    din = rand_beat();
    din[0*IN_W +: IN_W] = 32'd100;
    din[1*IN_W +: IN_W] = 32'd300;
    din[2*IN_W +: IN_W] = -32'sd300;
    send(din);
    tick();
    chk("s0_lanes", bus.q_data[3*OUT_W-1:0], 24'h80_7F_64);
    tick();

    arm(32'h8000_0000, "max_neg_ovf");
    din = rand_beat();
    din[0*IN_W +: IN_W] = 32'h7FFF_FFFF;
    din[1*IN_W +: IN_W] = 32'h8000_0000;
    send(din);
    tick();
    chk("s25_lanes", bus.q_data[2*OUT_W-1:0], 16'hC0_40);
    tick();

    // Stream at shift 3, then a new max-abs lands on top of a beat.
    arm(32'd1000, "rearm1000");
    repeat (4) send(rand_beat());
    bus.maxAbs       = 32'd50;
    bus.maxAbs_valid = 1'b1;
    send(rand_beat());
    n = 0;
    while (bus.busy && n < 100) begin
      n++;
      send(rand_beat());
    end
    chk("scan_drop_err", bus.drop_err, 1'b1);
    chk("max50_shift_out", bus.shift_out, 5'd0);
    repeat (3) tick();

    // Reset in the middle of a scan.
    bus.maxAbs       = 32'd1000;
    bus.maxAbs_valid = 1'b1;
    tick();
    repeat (5) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("busy_after_rst", bus.busy, 1'b0);
    tick();

    for (int r = 0; r < 20; r++) begin
      logic [IN_W-1:0] m;
      m = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 7) == 0) m = 32'h8000_0000;
      if ($urandom_range(0, 7) == 0) m = '0;
      bus.maxAbs       = m;
      bus.maxAbs_valid = 1'b1;
      bus.data_valid   = ($urandom_range(0, 3) != 0);
      bus.data_in      = rand_beat();
      tick();
      n = $urandom_range(10, 60);
      for (int c = 0; c < n; c++) begin
        bus.data_valid = ($urandom_range(0, 3) != 0);
        bus.data_in    = rand_beat();
        tick();
      end
    end

    repeat (5) tick();
    chk("scoreboard_drained", sbq.size(), 0);
    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
